// File: rtl/taiga_pipelined_adder.sv
// taiga_pipelined_adder
//   Fixed-latency integer add unit with an in-order result buffer.
//   An accepted operation is computed and carried through a valid-tagged
//   shift register. It lands in the result FIFO exactly STAGES cycles after
//   acceptance. Issue is throttled by the in-flight count (pipeline valids
//   plus FIFO occupancy), so every result already has a FIFO slot reserved
//   when it is issued.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset (control state only)
//   issue_new    issue strobe; accepted when issue_new && issue_ready
//   issue_ready  unit can accept an operation this cycle
//   issue_id     instruction id of the issued operation
//   rs1, rs2     source operands
//   op           00 ADD, 01 SUB, 10 CARRY, 11 ADDSAT
//   wb_done      head result valid
//   wb_id        head result id (0 while empty)
//   wb_rd        head result data (0 while empty)
//   wb_ack       writeback consumed; head pops when wb_done && wb_ack
module taiga_pipelined_adder #(
    parameter int XLEN       = 32,
    parameter int STAGES     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_new,
    output logic            issue_ready,
    input  logic [ID_W-1:0] issue_id,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [1:0]      op,
    output logic            wb_done,
    output logic [ID_W-1:0] wb_id,
    output logic [XLEN-1:0] wb_rd,
    input  logic            wb_ack
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Wide enough for the pipeline valids plus a full FIFO.
    localparam int IF_W  = $clog2(FIFO_DEPTH + STAGES) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [XLEN:0]    ONE_X   = (XLEN + 1)'(1);

    // Unsigned saturation: carry-out clamps the result to all-ones.
    function automatic logic [XLEN-1:0] sat_add(input logic [XLEN:0] sum);
        return sum[XLEN] ? {XLEN{1'b1}} : sum[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] alu(input logic [1:0]      mode,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic [XLEN:0] sum_add;
        logic [XLEN:0] sum_sub;
        logic [XLEN-1:0] res;
        sum_add = {1'b0, a} + {1'b0, b};
        sum_sub = {1'b0, a} + {1'b0, ~b} + ONE_X;
        case (mode)
            2'b00:   res = sum_add[XLEN-1:0];
            2'b01:   res = sum_sub[XLEN-1:0];
            2'b10:   res = {{(XLEN-1){1'b0}}, sum_add[XLEN]};
            default: res = sat_add(sum_add);
        endcase
        return res;
    endfunction

    logic            accept;
    logic [XLEN-1:0] data_in;
    logic            push;
    logic [ID_W-1:0] push_id;
    logic [XLEN-1:0] push_data;
    logic [IF_W-1:0] pipe_cnt;
    logic            pop;

    logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
    logic [XLEN-1:0]  mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IF_W-1:0]  in_flight;

    assign accept  = issue_new && issue_ready;
    assign data_in = alu(op, rs1, rs2);

    // Acceptance register plus STAGES-2 further stages; the FIFO write is
    // the final register of the latency chain.
    if (STAGES > 1) begin : g_pipe
        logic [STAGES-2:0] vld_p;
        logic [ID_W-1:0]   id_p   [STAGES-1];
        logic [XLEN-1:0]   data_p [STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= accept;
                for (int i = 1; i < STAGES - 1; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            id_p[0]   <= issue_id;
            data_p[0] <= data_in;
            for (int i = 1; i < STAGES - 1; i++) begin
                id_p[i]   <= id_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end

        assign push      = vld_p[STAGES-2];
        assign push_id   = id_p[STAGES-2];
        assign push_data = data_p[STAGES-2];
        assign pipe_cnt  = IF_W'($countones(vld_p));
    end else begin : g_nopipe
        assign push      = accept;
        assign push_id   = issue_id;
        assign push_data = data_in;
        assign pipe_cnt  = '0;
    end

    // ---- result FIFO ----
    assign pop = wb_ack && wb_done;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= push_id;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Slots are reserved at issue time, so the FIFO can never be full on push.
    a_no_push_on_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == DEPTH_C)));

    assign in_flight   = pipe_cnt + IF_W'(count);
    assign issue_ready = in_flight < IF_W'(FIFO_DEPTH);

    assign wb_done = (count != '0);
    assign wb_id   = wb_done ? mem_id[rd_ptr]   : '0;
    assign wb_rd   = wb_done ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_taiga_pipelined_adder.sv
// Directed bench for taiga_pipelined_adder (XLEN=32, STAGES=2, FIFO_DEPTH=4).
module tb_taiga_pipelined_adder;

    localparam int XLEN       = 32;
    localparam int STAGES     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CRY = 2'b10;
    localparam logic [1:0] OP_SAT = 2'b11;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_new;
    logic            issue_ready;
    logic [ID_W-1:0] issue_id;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [1:0]      op;
    logic            wb_done;
    logic [ID_W-1:0] wb_id;
    logic [XLEN-1:0] wb_rd;
    logic            wb_ack;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    taiga_pipelined_adder #(
        .XLEN(XLEN), .STAGES(STAGES), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .issue_new(issue_new), .issue_ready(issue_ready),
        .issue_id(issue_id), .rs1(rs1), .rs2(rs2), .op(op),
        .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [ID_W-1:0] id);
        issue_new = 1'b1;
        op        = o;
        rs1       = a;
        rs2       = b;
        issue_id  = id;
    endtask

    // Single isolated operation: no result after one cycle, result after two.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [ID_W-1:0] id,
                          input logic [31:0] exp);
        drive(o, a, b, id);
        chk({tag, "_ready"}, 32'(issue_ready), 32'd1);
        step();
        issue_new = 1'b0;
        chk({tag, "_nobypass"}, 32'(wb_done), 32'd0);
        step();
        chk({tag, "_done"}, 32'(wb_done), 32'd1);
        chk({tag, "_rd"}, wb_rd, exp);
        chk({tag, "_id"}, 32'(wb_id), 32'(id));
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        chk({tag, "_popped"}, 32'(wb_done), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        issue_new = 1'b0;
        issue_id  = '0;
        rs1       = '0;
        rs2       = '0;
        op        = OP_ADD;
        wb_ack    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_done", 32'(wb_done), 32'd0);
        chk("rst_id", 32'(wb_id), 32'd0);
        chk("rst_rd", wb_rd, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(issue_ready), 32'd1);
        chk("post_rst_done", 32'(wb_done), 32'd0);

        // Single operations in every mode
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 3'd5, 32'h0);
        run_op("add_plain", OP_ADD, 32'h1234_5678, 32'h1111_1111, 3'd1, 32'h2345_6789);
        run_op("carry_set", OP_CRY, 32'hFFFF_FFFF, 32'h1, 3'd2, 32'h1);
        run_op("carry_clr", OP_CRY, 32'h0000_0001, 32'h2, 3'd3, 32'h0);
        run_op("sat_clamp", OP_SAT, 32'hFFFF_FFF0, 32'h20, 3'd4, 32'hFFFF_FFFF);
        run_op("sat_plain", OP_SAT, 32'h5, 32'h7, 3'd6, 32'hC);
        run_op("sub_wrap", OP_SUB, 32'h0, 32'h1, 3'd7, 32'hFFFF_FFFF);
        run_op("sub_plain", OP_SUB, 32'hA, 32'h3, 3'd0, 32'h7);

        // Backpressure: only FIFO_DEPTH accepted while wb_ack is low
        wb_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(OP_ADD, 32'h100 + 32'(i), 32'(i), 3'(i));
            chk("fill_ready", 32'(issue_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        issue_new = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("full_ready", 32'(issue_ready), 32'd0);
            chk("full_done", 32'(wb_done), 32'd1);
            chk("full_hold_rd", wb_rd, 32'h100);
            chk("full_hold_id", 32'(wb_id), 32'd0);
            step();
        end
        for (int j = 0; j < 4; j++) begin
            chk("drain_done", 32'(wb_done), 32'd1);
            chk("drain_rd", wb_rd, 32'h100 + 32'(2 * j));
            chk("drain_id", 32'(wb_id), 32'(j));
            wb_ack = 1'b1;
            step();
        end
        wb_ack = 1'b0;
        chk("drained_done", 32'(wb_done), 32'd0);
        chk("drained_ready", 32'(issue_ready), 32'd1);

        // Back-to-back throughput with wb_ack held high
        wb_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                drive(OP_ADD, 32'(3 * c), 32'h1000, 3'(c % 8));
                chk("thru_ready", 32'(issue_ready), 32'd1);
            end else begin
                issue_new = 1'b0;
            end
            step();
            if (c + 1 >= 2 && c + 1 <= 17) begin
                chk("thru_done", 32'(wb_done), 32'd1);
                chk("thru_rd", wb_rd, 32'h1000 + 32'(3 * (c - 1)));
                chk("thru_id", 32'(wb_id), 32'((c - 1) % 8));
            end else begin
                chk("thru_idle", 32'(wb_done), 32'd0);
            end
        end
        wb_ack = 1'b0;

        // Reset mid-stream: three results buffered, one in flight
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADD, 32'h700 + 32'(i), 32'h0, 3'(i + 1));
            step();
        end
        issue_new = 1'b0;
        chk("pre_rst_done", 32'(wb_done), 32'd1);
        chk("pre_rst_id", 32'(wb_id), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_done", 32'(wb_done), 32'd0);
        chk("midrst_id", 32'(wb_id), 32'd0);
        chk("midrst_rd", wb_rd, 32'd0);
        step();
        rst = 1'b0;
        chk("midrst_ready", 32'(issue_ready), 32'd1);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("no_stale", 32'(wb_done), 32'd0);
        end
        run_op("post_midrst", OP_ADD, 32'h7, 32'h8, 3'd6, 32'hF);

        // Simultaneous push and pop across several pointer laps
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADD, 32'h100 + 32'(i), 32'(i), 3'(i));
            step();
        end
        issue_new = 1'b0;
        step();
        chk("lap_full_ready", 32'(issue_ready), 32'd0);
        chk("lap_full_done", 32'(wb_done), 32'd1);
        wb_ack = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            if (k <= 14) begin
                drive(OP_SUB, 32'h5000, (k == 0) ? 32'd0 : 32'(k - 1),
                      (k == 0) ? 3'd0 : 3'((k - 1) % 8));
            end else begin
                issue_new = 1'b0;
            end
            if (k <= 17) begin
                chk("lap_ready", 32'(issue_ready), (k == 0) ? 32'd0 : 32'd1);
                chk("lap_done", 32'(wb_done), 32'd1);
                if (k < 4) begin
                    chk("lap_rd", wb_rd, 32'h100 + 32'(2 * k));
                    chk("lap_id", 32'(wb_id), 32'(k));
                end else begin
                    chk("lap_rd", wb_rd, 32'h5000 - 32'(k - 4));
                    chk("lap_id", 32'(wb_id), 32'((k - 4) % 8));
                end
            end else begin
                chk("lap_empty", 32'(wb_done), 32'd0);
                chk("lap_end_ready", 32'(issue_ready), 32'd1);
            end
            step();
        end
        // wb_ack stayed high on an empty FIFO; that pop must be ignored.
        wb_ack = 1'b0;
        chk("empty_pop_ignored", 32'(wb_done), 32'd0);
        run_op("final", OP_CRY, 32'h1, 32'h2, 3'd7, 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
